fb_stream_writer: RTL and testbench

- Write-side counterpart of the VGA framebuffer read path.
- Accepts a raster-ordered pixel stream from a producer (scaler/ALU) through a valid/ready handshake.
- Drives the write port of the dual-port framebuffer RAM: address, data, write enable.
- Generates linear addresses row*img_w + col for an image of run-time size, then signals completion so the control unit can switch display modes.

---
 rtl/fb_stream_writer_pkg.sv | 27 ++
 rtl/fb_stream_writer_if.sv | 25 ++
 rtl/fb_raster_counter.sv | 43 ++++
 rtl/fb_stream_writer.sv | 179 +++++++++++++++++
 tb/tb_fb_stream_writer.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_stream_writer_pkg.sv
// Shared definitions for the framebuffer write path: FSM encoding, default widths
// and the framebuffer geometry constants also used by the control unit.
package fb_stream_writer_pkg;

    localparam int unsigned FB_W       = 640;
    localparam int unsigned FB_H       = 480;
    localparam int unsigned DEF_ADDR_W = 19;
    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DIM_W      = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        WRITE  = 2'd2,
        FINISH = 2'd3
    } wr_state_t;

    function automatic logic size_legal(
        input logic [DIM_W-1:0] w,
        input logic [DIM_W-1:0] h,
        input logic [DIM_W-1:0] max_w,
        input logic [DIM_W-1:0] max_h
    );
        return (w != '0) && (w <= max_w) && (h != '0) && (h <= max_h);
    endfunction

endpackage

// File: rtl/fb_stream_writer_if.sv
// Pixel stream (valid/ready) plus framebuffer RAM write port.
// master = producer side, slave = the writer.
interface fb_stream_writer_if #(
    parameter int unsigned ADDR_W = fb_stream_writer_pkg::DEF_ADDR_W,
    parameter int unsigned DATA_W = fb_stream_writer_pkg::DEF_DATA_W
);

    logic              pix_valid;
    logic [DATA_W-1:0] pix_data;
    logic              pix_ready;
    logic [ADDR_W-1:0] ram_wraddr;
    logic [DATA_W-1:0] ram_data;
    logic              ram_wren;

    modport master (
        output pix_valid, pix_data,
        input  pix_ready, ram_wraddr, ram_data, ram_wren
    );

    modport slave (
        input  pix_valid, pix_data,
        output pix_ready, ram_wraddr, ram_data, ram_wren
    );

endinterface

// File: rtl/fb_raster_counter.sv
// Raster col/row/linear-address counter with wrap and a last-pixel flag; the
// linear address is incremented rather than computed as row*width+col.
module fb_raster_counter
    import fb_stream_writer_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              advance,
    input  logic [DIM_W-1:0]  width,
    input  logic [DIM_W-1:0]  height,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [DIM_W-1:0] col;
    logic [DIM_W-1:0] row;
    logic             col_end;
    logic             row_end;

    assign col_end = (col == width - DIM_W'(1));
    assign row_end = (row == height - DIM_W'(1));
    assign last    = col_end && row_end;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
        end else if (advance) begin
            addr <= addr + ADDR_W'(1);
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + DIM_W'(1);
            end else begin
                col <= col + DIM_W'(1);
            end
        end
    end

endmodule

// File: rtl/fb_stream_writer.sv
// Writes a raster pixel stream into the framebuffer RAM at row*img_w+col.
// Define FB_STREAM_WRITER_CLEAR_EN to zero the whole MAX_W x MAX_H area before each frame.
module fb_stream_writer
    import fb_stream_writer_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned MAX_W  = FB_W,
    parameter int unsigned MAX_H  = FB_H
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [DIM_W-1:0] img_w,
    input  logic [DIM_W-1:0] img_h,
    fb_stream_writer_if.slave bus,
    output logic             busy,
    output logic             done,
    output logic             err_size
);

    if ((64'(MAX_W) * 64'(MAX_H) > (64'd1 << ADDR_W)) || (MAX_W >= (1 << DIM_W)) ||
        (MAX_H >= (1 << DIM_W))) begin : g_bad_geometry
        $error("fb_stream_writer: MAX_W x MAX_H does not fit the address or size width");
    end

    localparam logic [DIM_W-1:0] MAX_W_D = DIM_W'(MAX_W);
    localparam logic [DIM_W-1:0] MAX_H_D = DIM_W'(MAX_H);

    wr_state_t         state_q;
    wr_state_t         state_d;
    logic [DIM_W-1:0]  w_q;
    logic [DIM_W-1:0]  h_q;
    logic [DIM_W-1:0]  cnt_w;
    logic [DIM_W-1:0]  cnt_h;
    logic [ADDR_W-1:0] cnt_addr;
    logic              cnt_last;
    logic              cnt_clear;
    logic              cnt_adv;
    logic              start_ok;
    logic              xfer;
    logic              load_size;
    logic              wren_d;
    logic              wren_q;
    logic [DATA_W-1:0] wdata_d;
    logic [DATA_W-1:0] wdata_q;
    logic [ADDR_W-1:0] waddr_d;
    logic [ADDR_W-1:0] waddr_q;
    logic              done_d;
    logic              done_q;
    logic              err_d;
    logic              err_q;

    assign start_ok = start && size_legal(img_w, img_h, MAX_W_D, MAX_H_D);
    assign xfer     = bus.pix_valid && (state_q == WRITE);

    // The clear sweep reuses the raster counter over the full framebuffer geometry.
`ifdef FB_STREAM_WRITER_CLEAR_EN
    assign cnt_w = (state_q == CLEAR) ? MAX_W_D : w_q;
    assign cnt_h = (state_q == CLEAR) ? MAX_H_D : h_q;
`else
    assign cnt_w = w_q;
    assign cnt_h = h_q;
`endif

    fb_raster_counter #(
        .ADDR_W (ADDR_W)
    ) u_counter (
        .clk     (clk),
        .reset   (reset),
        .clear   (cnt_clear),
        .advance (cnt_adv),
        .width   (cnt_w),
        .height  (cnt_h),
        .addr    (cnt_addr),
        .last    (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
`ifdef FB_STREAM_WRITER_CLEAR_EN
            IDLE:    if (start_ok) state_d = CLEAR;
            CLEAR:   if (cnt_last) state_d = WRITE;
`else
            IDLE:    if (start_ok) state_d = WRITE;
`endif
            WRITE:   if (xfer && cnt_last) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // RAM port values are computed here and registered below, giving the
    // one-cycle latency from an accepted pixel to its write.
    always_comb begin
        bus.pix_ready = 1'b0;
        busy          = (state_q != IDLE);
        wren_d        = 1'b0;
        wdata_d       = wdata_q;
        waddr_d       = waddr_q;
        done_d        = 1'b0;
        err_d         = 1'b0;
        cnt_clear     = 1'b0;
        cnt_adv       = 1'b0;
        load_size     = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_clear = 1'b1;
                if (start) begin
                    load_size = start_ok;
                    err_d     = !start_ok;
                end
            end
`ifdef FB_STREAM_WRITER_CLEAR_EN
            CLEAR: begin
                wren_d    = 1'b1;
                wdata_d   = '0;
                waddr_d   = cnt_addr;
                cnt_adv   = 1'b1;
                cnt_clear = cnt_last;
            end
`endif
            WRITE: begin
                bus.pix_ready = 1'b1;
                if (xfer) begin
                    wren_d  = 1'b1;
                    wdata_d = bus.pix_data;
                    waddr_d = cnt_addr;
                    cnt_adv = 1'b1;
                end
            end
            FINISH: begin
                cnt_clear = 1'b1;
                done_d    = 1'b1;
            end
            default: begin
                cnt_clear = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_q     <= '0;
            h_q     <= '0;
            wren_q  <= 1'b0;
            wdata_q <= '0;
            waddr_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (load_size) begin
                w_q <= img_w;
                h_q <= img_h;
            end
            wren_q  <= wren_d;
            wdata_q <= wdata_d;
            waddr_q <= waddr_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.ram_wren   = wren_q;
    assign bus.ram_data   = wdata_q;
    assign bus.ram_wraddr = waddr_q;
    assign done           = done_q;
    assign err_size       = err_q;

endmodule

// File: tb/tb_fb_stream_writer.sv
// Randomized bench for fb_stream_writer: a negedge monitor logs writes, transfers and
// pulses; each test compares the log with a row-major frame model built in the bench.
module tb_fb_stream_writer;
    import fb_stream_writer_pkg::*;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 8;
`ifdef FB_STREAM_WRITER_CLEAR_EN
    localparam int MAX_W = 4;
    localparam int MAX_H = 2;
`else
    localparam int MAX_W = 640;
    localparam int MAX_H = 480;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [9:0] img_w = '0;
    logic [9:0] img_h = '0;
    logic       busy;
    logic       done;
    logic       err_size;

    fb_stream_writer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    fb_stream_writer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .MAX_W  (MAX_W),
        .MAX_H  (MAX_H)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .img_w    (img_w),
        .img_h    (img_h),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .err_size (err_size)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int start_cyc = 0;
    int busy_cnt = 0;

    int         wr_cyc[$];
    int         wr_addr[$];
    logic [7:0] wr_data[$];
    int         xfer_cyc[$];
    int         done_cyc[$];
    logic       done_busy[$];
    int         err_cyc[$];
    int         exp_addr[$];
    logic [7:0] exp_data[$];
    logic [7:0] pix [0:19199];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.ram_wren) begin
            wr_cyc.push_back(cyc);
            wr_addr.push_back(int'(bus.ram_wraddr));
            wr_data.push_back(bus.ram_data);
        end
        if (bus.pix_valid && bus.pix_ready) xfer_cyc.push_back(cyc);
        if (done) begin
            done_cyc.push_back(cyc);
            done_busy.push_back(busy);
        end
        if (err_size) err_cyc.push_back(cyc);
        if (busy) busy_cnt++;
    end

    task automatic clear_log();
        wr_cyc.delete(); wr_addr.delete(); wr_data.delete(); xfer_cyc.delete();
        done_cyc.delete(); done_busy.delete(); err_cyc.delete();
        busy_cnt = 0;
    endtask

    // Frame model: pixel k of the stream lands at row*w+col in row-major order.
    task automatic build_model(input int w, input int h);
        exp_addr.delete(); exp_data.delete();
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++) begin
                exp_addr.push_back(r * w + c);
                exp_data.push_back(pix[r * w + c]);
            end
    endtask

    task automatic randomize_pixels(input int n);
        for (int i = 0; i < n; i++) pix[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic start_frame(input int w, input int h);
        @(posedge clk); #1;
        start = 1'b1; img_w = 10'(w); img_h = 10'(h);
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // mode 0: valid held high, 1: valid every other cycle, 2: random valid
    task automatic drive_pixels(input int n, input int mode, input int stop_after,
                                output int accepted);
        int   k = 0;
        logic acc;
        accepted = 0;
        while (accepted < n && accepted < stop_after && k < n * 8 + 64) begin
            case (mode)
                0:       bus.pix_valid = 1'b1;
                1:       bus.pix_valid = (k % 2 == 0);
                default: bus.pix_valid = 1'($urandom_range(0, 1));
            endcase
            bus.pix_data = pix[accepted];
            @(negedge clk);
            acc = bus.pix_valid && bus.pix_ready;
            @(posedge clk); #1;
            if (acc) accepted++;
            k++;
        end
        bus.pix_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && done_cyc.size() == 0; i++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests_run++; if (bus.pix_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_pix_ready got %b want 0", bus.pix_ready); end
        tests_run++; if (bus.ram_wren !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_wren got %b want 0", bus.ram_wren); end
        tests_run++; if (bus.ram_wraddr !== '0) begin tests_failed++; $display("[TB] FAIL reset_wraddr got %0d want 0", bus.ram_wraddr); end
        tests_run++; if (bus.ram_data !== '0) begin tests_failed++; $display("[TB] FAIL reset_data got %0h want 0", bus.ram_data); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_done got %b want 0", done); end
        tests_run++; if (err_size !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_err got %b want 0", err_size); end
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL idle_busy got %b want 0", busy); end
    endtask

    task automatic test_basic_4x2();
        int acc;
        for (int i = 0; i < 8; i++) pix[i] = 8'(8'h10 + i);
        clear_log();
        build_model(4, 2);
        start_frame(4, 2);
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic_busy got %b want 1", busy); end
        drive_pixels(8, 0, 8, acc);
        wait_done();
        tests_run++; if (wr_addr.size() != 8) begin tests_failed++; $display("[TB] FAIL basic_count got %0d want 8", wr_addr.size()); end
        for (int i = 0; i < wr_addr.size() && i < 8; i++) begin
            tests_run++;
            if (wr_addr[i] != exp_addr[i] || wr_data[i] !== exp_data[i]) begin
                tests_failed++;
                $display("[TB] FAIL basic_write[%0d] got %0d/%0h want %0d/%0h", i, wr_addr[i], wr_data[i], exp_addr[i], exp_data[i]);
            end
        end
        if (wr_cyc.size() > 0) begin
            tests_run++; if (wr_cyc[$] - wr_cyc[0] != wr_cyc.size() - 1) begin tests_failed++; $display("[TB] FAIL basic_back_to_back span got %0d want %0d", wr_cyc[$] - wr_cyc[0], wr_cyc.size() - 1); end
        end
        tests_run++; if (done_cyc.size() != 1) begin tests_failed++; $display("[TB] FAIL basic_done_count got %0d want 1", done_cyc.size()); end
        if (done_cyc.size() > 0 && wr_cyc.size() > 0) begin
            tests_run++; if (done_cyc[0] != wr_cyc[$] + 1) begin tests_failed++; $display("[TB] FAIL basic_done_time got %0d want %0d", done_cyc[0], wr_cyc[$] + 1); end
            tests_run++; if (done_busy[0] !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_busy_at_done got %b want 0", done_busy[0]); end
        end
    endtask

    task automatic test_toggle_3x3();
        int acc;
        randomize_pixels(9);
        clear_log();
        build_model(3, 3);
        start_frame(3, 3);
        drive_pixels(9, 1, 9, acc);
        wait_done();
        tests_run++; if (wr_addr.size() != 9 || xfer_cyc.size() != 9) begin tests_failed++; $display("[TB] FAIL toggle_count got %0d writes %0d xfers want 9", wr_addr.size(), xfer_cyc.size()); end
        for (int i = 0; i < wr_addr.size() && i < 9 && i < xfer_cyc.size(); i++) begin
            tests_run++;
            if (wr_addr[i] != exp_addr[i] || wr_data[i] !== exp_data[i] || wr_cyc[i] != xfer_cyc[i] + 1) begin
                tests_failed++;
                $display("[TB] FAIL toggle_write[%0d] got %0d/%0h@%0d want %0d/%0h@%0d", i, wr_addr[i], wr_data[i], wr_cyc[i], exp_addr[i], exp_data[i], xfer_cyc[i] + 1);
            end
        end
        tests_run++; if (done_cyc.size() != 1) begin tests_failed++; $display("[TB] FAIL toggle_done_count got %0d want 1", done_cyc.size()); end
    endtask

    task automatic test_random_frames();
        int acc, w, h, n, bad;
        for (int f = 0; f < 6; f++) begin
            w = (f == 0) ? 1 : int'($urandom_range(1, 12));
            h = (f == 0) ? 1 : int'($urandom_range(1, 6));
            n = w * h;
            randomize_pixels(n);
            clear_log();
            build_model(w, h);
            start_frame(w, h);
            drive_pixels(n, 2, n, acc);
            wait_done();
            bad = 0;
            for (int i = 0; i < wr_addr.size() && i < n && i < xfer_cyc.size(); i++)
                if (wr_addr[i] != exp_addr[i] || wr_data[i] !== exp_data[i] || wr_cyc[i] != xfer_cyc[i] + 1) bad++;
            tests_run++; if (wr_addr.size() != n || bad != 0) begin tests_failed++; $display("[TB] FAIL rand_frame %0dx%0d got %0d writes %0d bad want %0d writes 0 bad", w, h, wr_addr.size(), bad, n); end
            tests_run++; if (done_cyc.size() != 1) begin tests_failed++; $display("[TB] FAIL rand_done %0dx%0d got %0d pulses want 1", w, h, done_cyc.size()); end
            if (done_cyc.size() > 0 && wr_cyc.size() > 0) begin
                tests_run++; if (done_cyc[0] != wr_cyc[$] + 1) begin tests_failed++; $display("[TB] FAIL rand_done_time %0dx%0d got %0d want %0d", w, h, done_cyc[0], wr_cyc[$] + 1); end
            end
        end
    endtask

    task automatic test_illegal_size();
        int bw[3];
        int bh[3];
`ifdef FB_STREAM_WRITER_CLEAR_EN
        bw = '{0, MAX_W + 1, 2}; bh = '{1, 1, MAX_H + 1};
`else
        bw = '{0, 641, 4};       bh = '{3, 3, 481};
`endif
        for (int t = 0; t < 3; t++) begin
            clear_log();
            start_frame(bw[t], bh[t]);
            repeat (4) @(posedge clk);
            #1;
            tests_run++; if (err_cyc.size() != 1) begin tests_failed++; $display("[TB] FAIL err_count %0dx%0d got %0d want 1", bw[t], bh[t], err_cyc.size()); end
            if (err_cyc.size() > 0) begin
                tests_run++; if (err_cyc[0] != start_cyc + 1) begin tests_failed++; $display("[TB] FAIL err_time got %0d want %0d", err_cyc[0], start_cyc + 1); end
            end
            tests_run++; if (busy_cnt != 0 || wr_addr.size() != 0) begin tests_failed++; $display("[TB] FAIL err_side_effects got busy %0d writes %0d want 0 0", busy_cnt, wr_addr.size()); end
        end
    endtask

    task automatic test_restart_ignored();
        int acc, bad;
        randomize_pixels(19200);
        clear_log();
        build_model(160, 120);
        start_frame(160, 120);
        fork
            drive_pixels(19200, 0, 19200, acc);
            begin
                repeat (500) @(posedge clk);
                #1;
                start = 1'b1; img_w = 10'd4; img_h = 10'd4;
                @(posedge clk); #1;
                start = 1'b0;
            end
        join
        wait_done();
        bad = 0;
        for (int i = 0; i < wr_addr.size() && i < 19200; i++)
            if (wr_addr[i] != exp_addr[i] || wr_data[i] !== exp_data[i]) bad++;
        tests_run++; if (wr_addr.size() != 19200 || bad != 0) begin tests_failed++; $display("[TB] FAIL restart_writes got %0d writes %0d bad want 19200 0", wr_addr.size(), bad); end
        if (wr_addr.size() > 0) begin
            tests_run++; if (wr_addr[$] != 19199) begin tests_failed++; $display("[TB] FAIL restart_last_addr got %0d want 19199", wr_addr[$]); end
        end
        tests_run++; if (done_cyc.size() != 1 || err_cyc.size() != 0) begin tests_failed++; $display("[TB] FAIL restart_pulses got done %0d err %0d want 1 0", done_cyc.size(), err_cyc.size()); end
    endtask

    task automatic test_reset_mid_frame();
        int acc;
        randomize_pixels(16);
        clear_log();
        start_frame(4, 4);
        drive_pixels(16, 0, 5, acc);
        reset = 1'b1;
        @(posedge clk); #1;
        tests_run++; if (bus.ram_wren !== 1'b0 || busy !== 1'b0 || bus.pix_ready !== 1'b0 || done !== 1'b0 || err_size !== 1'b0)
            begin tests_failed++; $display("[TB] FAIL abort_ctrl got wren %b busy %b ready %b done %b err %b want all 0", bus.ram_wren, busy, bus.pix_ready, done, err_size); end
        tests_run++; if (bus.ram_wraddr !== '0 || bus.ram_data !== '0) begin tests_failed++; $display("[TB] FAIL abort_port got %0d/%0h want 0/0", bus.ram_wraddr, bus.ram_data); end
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        tests_run++; if (wr_addr.size() != 5 || done_cyc.size() != 0) begin tests_failed++; $display("[TB] FAIL abort_log got %0d writes %0d done want 5 0", wr_addr.size(), done_cyc.size()); end
        randomize_pixels(4);
        clear_log();
        build_model(2, 2);
        start_frame(2, 2);
        drive_pixels(4, 0, 4, acc);
        wait_done();
        tests_run++; if (wr_addr.size() != 4 || done_cyc.size() != 1) begin tests_failed++; $display("[TB] FAIL after_abort_count got %0d writes %0d done want 4 1", wr_addr.size(), done_cyc.size()); end
        for (int i = 0; i < wr_addr.size() && i < 4; i++) begin
            tests_run++; if (wr_addr[i] != exp_addr[i] || wr_data[i] !== exp_data[i]) begin tests_failed++; $display("[TB] FAIL after_abort_write[%0d] got %0d/%0h want %0d/%0h", i, wr_addr[i], wr_data[i], exp_addr[i], exp_data[i]); end
        end
    endtask

`ifdef FB_STREAM_WRITER_CLEAR_EN
    task automatic test_clear();
        int acc;
        int         cl_addr[$];
        logic [7:0] cl_data[$];
        randomize_pixels(2);
        clear_log();
        build_model(2, 1);
        for (int i = 0; i < MAX_W * MAX_H; i++) begin cl_addr.push_back(i); cl_data.push_back(8'h00); end
        exp_addr = {cl_addr, exp_addr};
        exp_data = {cl_data, exp_data};
        start_frame(2, 1);
        drive_pixels(2, 0, 2, acc);
        wait_done();
        tests_run++; if (wr_addr.size() != exp_addr.size() || xfer_cyc.size() != 2) begin tests_failed++; $display("[TB] FAIL clear_count got %0d writes %0d xfers want %0d 2", wr_addr.size(), xfer_cyc.size(), exp_addr.size()); end
        for (int i = 0; i < wr_addr.size() && i < exp_addr.size(); i++) begin
            tests_run++; if (wr_addr[i] != exp_addr[i] || wr_data[i] !== exp_data[i] || wr_cyc[i] != wr_cyc[0] + i) begin tests_failed++; $display("[TB] FAIL clear_write[%0d] got %0d/%0h@%0d want %0d/%0h@%0d", i, wr_addr[i], wr_data[i], wr_cyc[i], exp_addr[i], exp_data[i], wr_cyc[0] + i); end
        end
        tests_run++; if (done_cyc.size() != 1) begin tests_failed++; $display("[TB] FAIL clear_done got %0d want 1", done_cyc.size()); end
    endtask
`endif

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired at cycle %0d want run complete", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bus.pix_valid = 1'b0;
        bus.pix_data  = '0;
        test_reset();
        test_illegal_size();
`ifdef FB_STREAM_WRITER_CLEAR_EN
        test_clear();
`else
        test_basic_4x2();
        test_toggle_3x3();
        test_random_frames();
        test_reset_mid_frame();
        test_restart_ignored();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
